// File: rtl/bound_flasher_pkg.sv
// Shared state encoding for the bound flasher family.
// Encodings are fixed because current_state is exported for debug/status.
package bound_flasher_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    UP_FULL = 3'd1,
    DN_A    = 3'd2,
    UP_B    = 3'd3,
    DN_ZERO = 3'd4,
    UP_A    = 3'd5,
    DN_END  = 3'd6,
    DN_K1   = 3'd7
  } bf_state_e;

  // Fill phases add a lamp per step; every other active phase removes one.
  function automatic logic is_up(input bf_state_e s);
    return (s == UP_FULL) || (s == UP_B) || (s == UP_A);
  endfunction

endpackage

// File: rtl/bound_flasher_param_prescaler.sv
// Step-rate divider: tick pulses once every STEP_DIV clocks; clear restarts the count.
module bf_step_prescaler #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count_reg;

  assign tick = (count_reg == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear || tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: thermometer LED bar driven through a fixed fill/drain sequence.
// Optional BOUND_FLASHER_SYNC_EN inserts a 2-flop synchroniser on flick.
module bound_flasher_param
  import bound_flasher_pkg::*;
#(
  parameter int N_LED    = 16,
  parameter int BOUND_A  = 5,
  parameter int BOUND_B  = 10,
  parameter int STEP_DIV = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flick,
  output logic [N_LED-1:0]             LED,
  output logic [STATE_W-1:0]           current_state,
  output logic [$clog2(N_LED+1)-1:0]   current_index
);

  localparam int IW = $clog2(N_LED + 1);
  localparam logic [IW-1:0] LIT_A    = IW'(BOUND_A);
  localparam logic [IW-1:0] LIT_A1   = IW'(BOUND_A + 1);
  localparam logic [IW-1:0] LIT_B1   = IW'(BOUND_B + 1);
  localparam logic [IW-1:0] LIT_FULL = IW'(N_LED);

  bf_state_e        state_reg;
  logic [IW-1:0]    lit_count_reg;
  logic [N_LED-1:0] led_reg;
  logic             flick_prev_reg;
  logic             flick_pend_reg;
  logic             flick_s;
  logic             flick_evt;
  logic             step_tick;
  logic             presc_clear;
  logic [IW-1:0]    lit_inc;
  logic [IW-1:0]    lit_dec;
  logic [N_LED-1:0] led_up;
  logic [N_LED-1:0] led_dn;

`ifdef BOUND_FLASHER_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], flick};
    end
  end

  assign flick_s = sync_reg[1];
`else
  assign flick_s = flick;
`endif

  assign flick_evt   = flick_s & ~flick_prev_reg;
  assign presc_clear = (state_reg == IDLE) && flick_evt;

  bf_step_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear),
    .tick  (step_tick)
  );

  // The bar is always a thermometer code, so a step is a one-bit shift.
  assign lit_inc = lit_count_reg + 1'b1;
  assign lit_dec = lit_count_reg - 1'b1;
  assign led_up  = {led_reg[N_LED-2:0], 1'b1};
  assign led_dn  = {1'b0, led_reg[N_LED-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      lit_count_reg  <= '0;
      led_reg        <= '0;
      flick_prev_reg <= 1'b0;
      flick_pend_reg <= 1'b0;
    end else begin
      flick_prev_reg <= flick_s;

      // A new event wins over the per-tick clear so it is seen on the following tick.
      if (flick_evt && (state_reg != IDLE)) begin
        flick_pend_reg <= 1'b1;
      end else if (step_tick) begin
        flick_pend_reg <= 1'b0;
      end

      if (state_reg == IDLE) begin
        if (flick_evt) begin
          state_reg <= UP_FULL;
        end
      end else if (step_tick) begin
        if (is_up(state_reg)) begin
          lit_count_reg <= lit_inc;
          led_reg       <= led_up;
        end else begin
          lit_count_reg <= lit_dec;
          led_reg       <= led_dn;
        end

        case (state_reg)
          UP_FULL: begin
            if (flick_pend_reg && ((lit_inc == LIT_A1) || (lit_inc == LIT_B1))) begin
              state_reg <= DN_K1;
            end else if (lit_inc == LIT_FULL) begin
              state_reg <= DN_A;
            end
          end
          DN_A:    if (lit_dec == LIT_A) state_reg <= UP_B;
          UP_B:    if (lit_inc == LIT_B1) state_reg <= flick_pend_reg ? DN_A : DN_ZERO;
          DN_ZERO: if (lit_dec == '0) state_reg <= UP_A;
          UP_A:    if (lit_inc == LIT_A1) state_reg <= flick_pend_reg ? DN_ZERO : DN_END;
          DN_END:  if (lit_dec == '0) state_reg <= IDLE;
          DN_K1:   if (lit_dec == '0) state_reg <= UP_FULL;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign LED           = led_reg;
  assign current_state = state_reg;
  assign current_index = lit_count_reg;

endmodule

// File: tb/tb_bound_flasher_param.sv
// Scoreboard bench: scenarios queue expected output changes, a monitor pops one per observed change.
module tb_bound_flasher_param;

`ifdef BOUND_FLASHER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flick = 1'b0;
  logic       flick2 = 1'b0;
  logic [15:0] led;
  logic [2:0]  st;
  logic [4:0]  idx;
  logic [7:0]  led2;
  logic [2:0]  st2;
  logic [3:0]  idx2;

  always #5 clk = ~clk;

  bound_flasher_param dut (
    .clk           (clk),
    .reset         (reset),
    .flick         (flick),
    .LED           (led),
    .current_state (st),
    .current_index (idx)
  );

  bound_flasher_param #(
    .N_LED    (8),
    .BOUND_A  (2),
    .BOUND_B  (5),
    .STEP_DIV (4)
  ) dut2 (
    .clk           (clk),
    .reset         (reset),
    .flick         (flick2),
    .LED           (led2),
    .current_state (st2),
    .current_index (idx2)
  );

  typedef struct {
    int dly;
    int st;
    int lit;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  int n_evt = 0;
  bit mon_en = 1'b0;
  logic [2:0]  prev_st;
  logic [4:0]  prev_idx;
  logic [15:0] prev_led;

  function automatic logic [15:0] therm16(input int n);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v[i] = (i < n);
    return v;
  endfunction

  task automatic push(input int dly, input int s, input int l);
    exp_t e;
    e.dly = dly;
    e.st  = s;
    e.lit = l;
    sb.push_back(e);
  endtask

  // Phase from lit a to lit b in state s, landing on b in state ns; one step per clock.
  task automatic seg(input int s, input int a, input int b, input int ns);
    int step;
    step = (b > a) ? 1 : -1;
    for (int v = a + step; v != b; v += step) push(1, s, v);
    push(1, ns, b);
  endtask

  task automatic full_from_up_full();
    seg(1, 0, 16, 2);
    seg(2, 16, 5, 3);
    seg(3, 5, 11, 4);
    seg(4, 11, 0, 5);
    seg(5, 0, 6, 6);
    seg(6, 6, 0, 0);
  endtask

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic wait_for(input int s, input int l, input int budget);
    int t;
    t = 0;
    while (!((st == 3'(s)) && (idx == 5'(l))) && (t < budget)) begin
      @(negedge clk);
      t++;
    end
    if (!((st == 3'(s)) && (idx == 5'(l)))) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_for: timeout, got state=%0d lit=%0d, want state=%0d lit=%0d", st, idx, s, l);
    end
  endtask

  task automatic start_flick();
    @(negedge clk);
    flick = 1'b1;
    @(negedge clk);
    flick = 1'b0;
    repeat (SYNC_LAT) @(negedge clk);
    check("start_state", st, 1);
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while ((sb.size() != 0) && (t < budget)) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected events never seen, want 0 left", sb.size());
      sb.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  // Monitor: every change of the DUT outputs is one transaction.
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en && ((st != prev_st) || (idx != prev_idx) || (led != prev_led))) begin
        n_cmp++;
        n_evt++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL event#%0d: unexpected change to state=%0d lit=%0d led=%h, want no change",
                   n_evt, st, idx, led);
        end else begin
          e = sb.pop_front();
          ok = (st == 3'(e.st)) && (idx == 5'(e.lit)) && (led == therm16(e.lit)) &&
               ((e.dly < 0) || ((cyc - last_cyc) == e.dly));
          if (!ok) begin
            n_bad++;
            $display("FAIL event#%0d: got state=%0d lit=%0d led=%h dly=%0d, want state=%0d lit=%0d led=%h dly=%0d",
                     n_evt, st, idx, led, cyc - last_cyc, e.st, e.lit, therm16(e.lit), e.dly);
          end else begin
            $display("event#%0d ok state=%0d lit=%0d led=%h", n_evt, st, idx, led);
          end
        end
        prev_st  = st;
        prev_idx = idx;
        prev_led = led;
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int first1;
    int first2;
    int peak;
    logic [7:0] peak_led;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_led", led, 0);
    check("rst_state", st, 0);
    check("rst_index", idx, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_led", led, 0);
    check("idle_state", st, 0);
    check("idle2_state", st2, 0);
    prev_st  = st;
    prev_idx = idx;
    prev_led = led;
    last_cyc = cyc;
    mon_en   = 1'b1;

    // 1: nominal sequence
    push(-1, 1, 0);
    full_from_up_full();
    start_flick();
    drain(200);

    // 2: kickback in UP_FULL at BOUND_A+1
    push(-1, 1, 0);
    seg(1, 0, 6, 7);
    seg(7, 6, 0, 1);
    full_from_up_full();
    start_flick();
    wait_for(1, 4 - SYNC_LAT, 50);
    flick = 1'b1;
    @(negedge clk);
    flick = 1'b0;
    drain(300);

    // 3: kickback in UP_B at BOUND_B+1
    push(-1, 1, 0);
    seg(1, 0, 16, 2);
    seg(2, 16, 5, 3);
    seg(3, 5, 11, 2);
    seg(2, 11, 5, 3);
    seg(3, 5, 11, 4);
    seg(4, 11, 0, 5);
    seg(5, 0, 6, 6);
    seg(6, 6, 0, 0);
    start_flick();
    wait_for(3, 9 - SYNC_LAT, 100);
    flick = 1'b1;
    @(negedge clk);
    flick = 1'b0;
    drain(300);

    // 4: flick during a drain is ignored; held high gives one event only
    push(-1, 1, 0);
    full_from_up_full();
    start_flick();
    wait_for(2, 6 + SYNC_LAT, 100);
    flick = 1'b1;
    repeat (40) @(negedge clk);
    flick = 1'b0;
    drain(300);
    check("held_end_state", st, 0);

    // 5: asynchronous reset mid UP_B
    push(-1, 1, 0);
    seg(1, 0, 16, 2);
    seg(2, 16, 5, 3);
    for (int v = 6; v <= 9; v++) push(1, 3, v);
    push(-1, 0, 0);
    start_flick();
    wait_for(3, 9, 100);
    check("pre_rst_led", led, 16'h01FF);
    #1 reset = 1'b1;
    #1;
    check("async_rst_led", led, 0);
    check("async_rst_state", st, 0);
    check("async_rst_index", idx, 0);
    @(negedge clk);
    reset = 1'b0;
    drain(20);
    push(-1, 1, 0);
    full_from_up_full();
    start_flick();
    drain(200);

    // 6: N_LED=8, BOUND_A=2, BOUND_B=5, STEP_DIV=4
    @(negedge clk);
    flick2 = 1'b1;
    @(negedge clk);
    flick2 = 1'b0;
    t = 1;
    while ((st2 != 3'd1) && (t < 20)) begin
      @(negedge clk);
      t++;
    end
    check("k2_start_lat", t, 1 + SYNC_LAT);
    t = 0;
    first1 = -1;
    first2 = -1;
    peak = 0;
    peak_led = '0;
    while ((st2 != 3'd0) && (t < 400)) begin
      @(negedge clk);
      t++;
      if ((idx2 == 4'd1) && (first1 < 0)) first1 = t;
      if ((idx2 == 4'd2) && (first2 < 0)) first2 = t;
      if (int'(idx2) > peak) begin
        peak = int'(idx2);
        peak_led = led2;
      end
    end
    check("k2_first_lamp", first1, 4);
    check("k2_second_lamp", first2, 8);
    check("k2_peak_index", peak, 8);
    check("k2_peak_led", peak_led, 8'hFF);
    check("k2_seq_cycles", t, 120);
    check("k2_end_led", led2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
